// File: rtl/lora_frame_rx_if.sv
// rtl/lora_frame_rx_if.sv - received-byte strobe bus between a UART receiver and lora_frame_rx
interface lora_frame_rx_if;
    logic       rx_valid;
    logic [7:0] rx_data;

    modport master (output rx_valid, output rx_data);
    modport slave  (input  rx_valid, input  rx_data);
endinterface

// File: rtl/lora_frame_rx.sv
// rtl/lora_frame_rx.sv - HDR/payload/[XOR checksum]/TRL byte-frame receiver with inter-byte timeout
// Optional checksum byte enabled by defining LORA_FRAME_CSUM_EN.
module lora_frame_rx #(
    parameter int         PAYLOAD_LEN = 1,
    parameter logic [7:0] HDR_BYTE    = 8'hAA,
    parameter logic [7:0] TRL_BYTE    = 8'hAA,
    parameter int         TIMEOUT_CYC = 50000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    lora_frame_rx_if.slave           rx,
    output logic [8*PAYLOAD_LEN-1:0] payload,
    output logic                     frame_ok,
    output logic                     frame_err,
    output logic [1:0]               err_code,
    output logic [7:0]               frame_cnt,
    output logic                     busy
);
    localparam int IW = (PAYLOAD_LEN > 1) ? $clog2(PAYLOAD_LEN) : 1;
    localparam int CW = $clog2(TIMEOUT_CYC);

`ifdef LORA_FRAME_CSUM_EN
    typedef enum logic [1:0] {IDLE, PAYLOAD, CSUM, TRAILER} state_t;
    localparam state_t AFTER_PAYLOAD = CSUM;
`else
    typedef enum logic [1:0] {IDLE, PAYLOAD, TRAILER} state_t;
    localparam state_t AFTER_PAYLOAD = TRAILER;
`endif

    state_t                   state;
    logic [8*PAYLOAD_LEN-1:0] shadow;
    logic [IW-1:0]            idx;
    logic [7:0]               csum;
    logic [CW-1:0]            tcnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            payload   <= '0;
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
            err_code  <= 2'b00;
            frame_cnt <= 8'd0;
            busy      <= 1'b0;
            shadow    <= '0;
            idx       <= '0;
            csum      <= 8'd0;
            tcnt      <= '0;
        end else begin
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    tcnt <= '0;
                    if (rx.rx_valid && rx.rx_data == HDR_BYTE) begin
                        state <= PAYLOAD;
                        busy  <= 1'b1;
                        idx   <= '0;
                        csum  <= 8'd0;
                    end
                end
                default: begin
                    // A byte arriving on the last allowed cycle takes priority over the timeout.
                    if (rx.rx_valid) begin
                        tcnt <= '0;
                        case (state)
                            PAYLOAD: begin
                                for (int i = 0; i < PAYLOAD_LEN; i++) begin
                                    if (idx == IW'(i))
                                        shadow[8*(PAYLOAD_LEN-1-i) +: 8] <= rx.rx_data;
                                end
                                csum <= csum ^ rx.rx_data;
                                if (idx == IW'(PAYLOAD_LEN-1))
                                    state <= AFTER_PAYLOAD;
                                else
                                    idx <= idx + IW'(1);
                            end
`ifdef LORA_FRAME_CSUM_EN
                            CSUM: begin
                                if (rx.rx_data == csum) begin
                                    state <= TRAILER;
                                end else begin
                                    state     <= IDLE;
                                    busy      <= 1'b0;
                                    frame_err <= 1'b1;
                                    err_code  <= 2'b10;
                                end
                            end
`endif
                            TRAILER: begin
                                state <= IDLE;
                                busy  <= 1'b0;
                                if (rx.rx_data == TRL_BYTE) begin
                                    payload   <= shadow;
                                    frame_ok  <= 1'b1;
                                    frame_cnt <= frame_cnt + 8'd1;
                                end else begin
                                    frame_err <= 1'b1;
                                    err_code  <= 2'b01;
                                end
                            end
                            default: begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end
                        endcase
                    end else if (tcnt == CW'(TIMEOUT_CYC-1)) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        tcnt      <= '0;
                        frame_err <= 1'b1;
                        err_code  <= 2'b11;
                    end else begin
                        tcnt <= tcnt + CW'(1);
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_lora_frame_rx.sv
// tb/tb_lora_frame_rx.sv - directed and randomized frame-level bench for lora_frame_rx
module tb_lora_frame_rx;
    localparam int         PL  = 2;
    localparam int         TO  = 16;
    localparam logic [7:0] HDR = 8'hAA;
    localparam logic [7:0] TRL = 8'hAA;

    typedef logic [7:0] bq_t[$];

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] payload;
    logic        frame_ok, frame_err, busy;
    logic [1:0]  err_code;
    logic [7:0]  frame_cnt;

    int checks = 0;
    int errors = 0;
    int ok_pulses = 0;

    logic [15:0] exp_payload = 16'h0;
    logic [1:0]  exp_code = 2'b00;
    logic [7:0]  exp_cnt = 8'd0;

    always #5 clk = ~clk;

    lora_frame_rx_if rx_if ();

    lora_frame_rx #(.PAYLOAD_LEN(PL), .HDR_BYTE(HDR), .TRL_BYTE(TRL), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst_n(rst_n), .rx(rx_if), .payload(payload), .frame_ok(frame_ok),
        .frame_err(frame_err), .err_code(err_code), .frame_cnt(frame_cnt), .busy(busy)
    );

    always @(negedge clk) if (frame_ok === 1'b1) ok_pulses++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Strobes are (gap+1) cycles apart; returns at the falling edge right after the last byte is sampled.
    task automatic send_bytes(input bq_t q, input int gap);
        for (int i = 0; i < q.size(); i++) begin
            @(negedge clk);
            rx_if.rx_valid = 1'b1;
            rx_if.rx_data  = q[i];
            if (gap > 0 && i != q.size() - 1) begin
                @(negedge clk);
                rx_if.rx_valid = 1'b0;
                repeat (gap - 1) @(negedge clk);
            end
        end
        @(negedge clk);
        rx_if.rx_valid = 1'b0;
    endtask

    // mode 0 good, 1 trailer replaced by bad, 2 checksum XORed with bad (frame stops there)
    function automatic bq_t build(input logic [7:0] p0, input logic [7:0] p1, input int mode,
                                  input logic [7:0] bad);
        bq_t q;
        q = {HDR, p0, p1};
`ifdef LORA_FRAME_CSUM_EN
        if (mode == 2) begin
            q.push_back((p0 ^ p1) ^ bad);
            return q;
        end
        q.push_back(p0 ^ p1);
`endif
        q.push_back(mode == 1 ? bad : TRL);
        return q;
    endfunction

    task automatic run_frame(input string tag, input logic [7:0] p0, input logic [7:0] p1,
                             input int mode, input int gap, input logic [7:0] bad);
        logic good;
        send_bytes(build(p0, p1, mode, bad), gap);
        good = (mode == 0);
        if (good) begin
            exp_payload = {p0, p1};
            exp_cnt     = exp_cnt + 8'd1;
        end else begin
            exp_code = (mode == 1) ? 2'b01 : 2'b10;
        end
        check({tag, ".ok"},      32'(frame_ok),  32'(good));
        check({tag, ".err"},     32'(frame_err), 32'(!good));
        check({tag, ".code"},    32'(err_code),  32'(exp_code));
        check({tag, ".payload"}, 32'(payload),   32'(exp_payload));
        check({tag, ".cnt"},     32'(frame_cnt), 32'(exp_cnt));
        check({tag, ".busy"},    32'(busy),      32'h0);
        @(negedge clk);
        check({tag, ".pulse"},   32'({frame_ok, frame_err}), 32'h0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".payload"}, 32'(payload), 32'h0);
        check({tag, ".flags"},   32'({frame_ok, frame_err, busy}), 32'h0);
        check({tag, ".code"},    32'(err_code), 32'h0);
        check({tag, ".cnt"},     32'(frame_cnt), 32'h0);
    endtask

    initial begin
        bq_t big;
        logic [7:0] a, b, bad;
        int mode;
        rx_if.rx_valid = 1'b0;
        rx_if.rx_data  = 8'h00;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_frame("good", 8'h12, 8'h34, 0, 3, 8'h00);
        run_frame("bad_trl", 8'h12, 8'h34, 1, 3, 8'hBB);
`ifdef LORA_FRAME_CSUM_EN
        run_frame("bad_csum", 8'h12, 8'h34, 2, 3, 8'h01);
        run_frame("after_csum", 8'hAA, 8'h01, 0, 3, 8'h00);
`endif

        send_bytes({HDR, 8'h12}, 3);
        repeat (TO - 1) @(negedge clk);
        check("to.before_busy", 32'(busy), 32'h1);
        check("to.before_err", 32'(frame_err), 32'h0);
        @(negedge clk);
        exp_code = 2'b11;
        check("to.err", 32'(frame_err), 32'h1);
        check("to.code", 32'(err_code), 32'(exp_code));
        check("to.busy", 32'(busy), 32'h0);
        check("to.payload", 32'(payload), 32'(exp_payload));

        send_bytes({HDR, 8'h12}, 3);
        repeat (TO - 2) @(negedge clk);
        big = build(8'h12, 8'h9C, 0, 8'h00);
        big = big[2:$];
        send_bytes(big, 3);
        exp_payload = 16'h129C;
        exp_cnt     = exp_cnt + 8'd1;
        check("to_win.ok", 32'(frame_ok), 32'h1);
        check("to_win.payload", 32'(payload), 32'(exp_payload));
        check("to_win.cnt", 32'(frame_cnt), 32'(exp_cnt));
        check("to_win.code", 32'(err_code), 32'(exp_code));

        send_bytes({HDR, 8'h12}, 3);
        rst_n = 1'b0;
        @(negedge clk);
        check_zero("mid_rst");
        @(negedge clk);
        rst_n = 1'b1;
        exp_payload = 16'h0; exp_code = 2'b00; exp_cnt = 8'd0;
        send_bytes({8'h34}, 3);
        check("rst.ignored_busy", 32'(busy), 32'h0);
        run_frame("rst.frame", 8'h56, 8'h78, 0, 3, 8'h00);

        for (int n = 0; n < 24; n++) begin
            a = 8'($urandom);
            b = 8'($urandom);
`ifdef LORA_FRAME_CSUM_EN
            mode = $urandom_range(0, 2);
`else
            mode = $urandom_range(0, 1);
`endif
            bad = 8'($urandom_range(1, 255));
            if (mode == 1 && bad == TRL) bad = bad ^ 8'h01;
            run_frame("rand", a, b, mode, $urandom_range(0, 5), bad);
        end

        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_payload = 16'h0; exp_code = 2'b00; exp_cnt = 8'd0;
        big = {};
        for (int n = 0; n < 256; n++) begin
            a = 8'($urandom);
            b = 8'($urandom);
            big = {big, build(a, b, 0, 8'h00)};
            exp_payload = {a, b};
        end
        @(negedge clk);
        ok_pulses = 0;
        send_bytes(big, 0);
        @(negedge clk);
        check("wrap.pulses", 32'(ok_pulses), 32'd256);
        check("wrap.cnt", 32'(frame_cnt), 32'h0);
        check("wrap.payload", 32'(payload), 32'(exp_payload));
        check("wrap.busy", 32'(busy), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/lora_frame_rx.md
LORA_FRAME_RX -- requirements
Module: lora_frame_rx

Interface
REQ-001 SHALL have parameter PAYLOAD_LEN, default 1, payload bytes per frame (legal range 1..16).
REQ-002 SHALL have parameter HDR_BYTE, default 8'hAA, frame header value.
REQ-003 SHALL have parameter TRL_BYTE, default 8'hAA, frame trailer value.
REQ-004 SHALL have parameter TIMEOUT_CYC, default 50000, maximum idle clk cycles between bytes inside a frame (minimum 2).
REQ-005 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port rx_valid  input  1  one-cycle strobe: rx_data holds a received UART byte.
REQ-008 SHALL have port rx_data  input  8  received byte, sampled only when rx_valid=1.
REQ-009 SHALL have port payload  output  8*PAYLOAD_LEN  last good payload; first received byte in the MSBs.
REQ-010 SHALL have port frame_ok  output  1  one-cycle pulse: good frame accepted.
REQ-011 SHALL have port frame_err  output  1  one-cycle pulse: frame discarded.
REQ-012 SHALL have port err_code  output  2  cause of the last error: 01 trailer, 10 checksum, 11 timeout.
REQ-013 SHALL have port frame_cnt  output  8  count of good frames, modulo 256.
REQ-014 SHALL have port busy  output  1  high while a frame is in progress (state not IDLE).

Function
REQ-015 SHALL implement states IDLE, PAYLOAD, CSUM, TRAILER, all outputs registered.
REQ-016 IDLE: rx_valid with rx_data==HDR_BYTE -> PAYLOAD, byte index=0, running XOR=0; any other byte ignored.
REQ-017 PAYLOAD: each rx_valid byte SHALL be written to a shadow buffer at the index and XORed into the running value; HDR_BYTE values are plain data here.
REQ-018 PAYLOAD: the byte at index PAYLOAD_LEN-1 -> CSUM when checksum is compiled in, else -> TRAILER.
REQ-019 CSUM: byte == running XOR -> TRAILER; mismatch -> frame_err, err_code=10, IDLE.
REQ-020 TRAILER: byte == TRL_BYTE -> payload<=shadow, frame_ok, frame_cnt+1, IDLE; mismatch -> frame_err, err_code=01, IDLE.
REQ-021 On the clock edge sampling the deciding byte, SHALL set frame_ok/frame_err, payload and frame_cnt together, so all are visible in the following cycle (1-cycle latency).
REQ-022 payload SHALL never be partially updated; on any error it SHALL keep its previous value.
REQ-023 Timeout counter SHALL clear on every accepted rx_valid and on entry to IDLE, and increment each cycle in a non-IDLE state without rx_valid.
REQ-024 Counter at TIMEOUT_CYC-1 with rx_valid=0 -> frame_err, err_code=11, IDLE; if rx_valid=1 in that cycle, the byte SHALL win and no timeout SHALL occur.
REQ-025 err_code SHALL hold its value until the next error.
REQ-026 frame_cnt SHALL wrap from 255 to 0 without any flag.
REQ-027 Byte strobes arriving on consecutive cycles SHALL each be processed with no byte lost.

Reset
REQ-028 rst_n low SHALL immediately force: state IDLE, payload=0, frame_ok=0, frame_err=0, err_code=00, frame_cnt=0, busy=0, shadow, index, XOR and timeout counter all 0.
REQ-029 Reset asserted mid-frame SHALL discard the partial frame; after release, only a new HDR_BYTE starts a frame.

Configuration
REQ-030 Macro LORA_FRAME_CSUM_EN defined: frame = HDR, payload, XOR checksum of payload bytes, TRL; CSUM state present.
REQ-031 Macro LORA_FRAME_CSUM_EN undefined: frame = HDR, payload, TRL; CSUM state absent; err_code 10 never produced.

Verification (PAYLOAD_LEN=2, TIMEOUT_CYC=16, bytes spaced 4 cycles apart unless stated)
REQ-032 Good frame: AA 12 34 AA (with CSUM_EN: AA 12 34 26 AA) -> payload=16'h1234, frame_ok high one cycle, frame_cnt=1, busy back to 0.
REQ-033 Bad trailer: AA 12 34 BB (CSUM_EN: AA 12 34 26 BB) -> frame_err pulse, err_code=01, payload unchanged, frame_cnt unchanged.
REQ-034 Bad checksum (CSUM_EN): AA 12 34 27 -> frame_err, err_code=10, state IDLE; the next AA starts a new frame.
REQ-035 Timeout: AA 12, then 16 cycles with no rx_valid -> frame_err, err_code=11, busy=0; a strobe in the 16th cycle instead SHALL continue the frame.
REQ-036 Reset: AA 12, then rst_n low for 2 cycles, then 34 AA 56 78 AA -> all outputs 0 during reset; 34 ignored; frame 56 78 accepted, payload=16'h5678.
REQ-037 Wrap: 256 back-to-back good frames (consecutive-cycle strobes) -> 256 frame_ok pulses, frame_cnt=0.
